cdc_hs_src: RTL and testbench

//   Source-domain side of a two-phase (toggle) req/ack handshake for moving multi-bit words

---
 rtl/cdc_hs_src_pkg.sv | 12 +
 rtl/cdc_hs_src_if.sv | 42 ++++
 rtl/cdc_hs_src_sync.sv | 30 +++
 rtl/cdc_hs_src.sv | 121 ++++++++++++
 tb/tb_cdc_hs_src.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_hs_src_pkg.sv
// Shared types and constants for the source side of the toggle req/ack CDC handshake.
package cdc_hs_src_pkg;

    typedef enum logic {
        HS_IDLE,
        HS_WAIT
    } cdc_hs_state_e;

    // Fewest flops allowed in a synchroniser chain
    localparam int unsigned CDC_MIN_STAGE = 2;

endpackage : cdc_hs_src_pkg

// File: rtl/cdc_hs_src_if.sv
// Handshake bundle between the source-side user port, the CDC link and the error port.
interface cdc_hs_src_if #(
    parameter int unsigned DATA_WIDTH = 32
);

    logic                  src_valid_i;
    logic                  src_ready_o;
    logic [DATA_WIDTH-1:0] src_data_i;
    logic                  cdc_req_o;
    logic [DATA_WIDTH-1:0] cdc_data_o;
    logic                  cdc_ack_i;
    logic                  busy_o;
    logic                  err_clr_i;
    logic                  err_o;

    // Handshake block view
    modport master (
        input  src_valid_i,
        input  src_data_i,
        input  cdc_ack_i,
        input  err_clr_i,
        output src_ready_o,
        output cdc_req_o,
        output cdc_data_o,
        output busy_o,
        output err_o
    );

    // Environment view (producer, destination and error handler)
    modport slave (
        output src_valid_i,
        output src_data_i,
        output cdc_ack_i,
        output err_clr_i,
        input  src_ready_o,
        input  cdc_req_o,
        input  cdc_data_o,
        input  busy_o,
        input  err_o
    );

endinterface : cdc_hs_src_if

// File: rtl/cdc_hs_src_sync.sv
// Multi-flop synchroniser bringing an asynchronous signal into the clk_i domain.
module cdc_hs_src_sync #(
    parameter int unsigned STAGE      = 2,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] r_chain [STAGE];

    // Shift the asynchronous input through the chain; clear on reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(STAGE); i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= d_i;
            for (int i = 1; i < int'(STAGE); i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q_o = r_chain[STAGE-1];

endmodule : cdc_hs_src_sync

// File: rtl/cdc_hs_src.sv
// Source side of a two-phase (toggle) req/ack handshake: captures one word, holds it on
// cdc_data_o, toggles cdc_req_o and waits for the synchronised ack toggle to match.
module cdc_hs_src
    import cdc_hs_src_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SYNC_STAGE = 2,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cdc_hs_src_if.master        hs
);

    if (SYNC_STAGE < CDC_MIN_STAGE) begin : g_stage_check
        $error("cdc_hs_src: SYNC_STAGE must be at least CDC_MIN_STAGE");
    end

    cdc_hs_state_e         r_state;
    cdc_hs_state_e         w_state_nxt;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_ack_sync;
    logic                  w_rst_n;
    logic                  w_ready;
    logic                  w_accept;

    assign w_rst_n = ~rst_i;

    // Bring the destination's ack toggle into this domain
    cdc_hs_src_sync #(
        .STAGE      (SYNC_STAGE),
        .DATA_WIDTH (1)
    ) u_ack_sync (
        .clk_i   (clk_i),
        .rst_n_i (w_rst_n),
        .d_i     (hs.cdc_ack_i),
        .q_o     (w_ack_sync)
    );

    // Idle and link settled: the last request has been acknowledged
    assign w_ready = (r_state == HS_IDLE) && (w_ack_sync == r_req);

    // Next-state and accept decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (hs.src_valid_i && w_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HS_WAIT;
                end
            end
            HS_WAIT: begin
                if (w_ack_sync == r_req) begin
                    w_state_nxt = HS_IDLE;
                end
            end
        endcase
    end

    // State, request toggle and held word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= HS_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= hs.src_data_i;
                r_req  <= ~r_req;
            end
        end
    end

    if (TIMEOUT > 0) begin : g_timeout
        localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

        logic [CNT_W-1:0] r_cnt;
        logic             r_err;
        logic             w_err_set;

        // Fires when WAIT reaches TIMEOUT cycles, and again after a clear while still stuck
        assign w_err_set = (r_state == HS_WAIT) &&
                           ((r_cnt == CNT_W'(TIMEOUT - 1)) ||
                            ((r_cnt == CNT_W'(TIMEOUT)) && !r_err));

        // WAIT cycle counter (saturating) and sticky error; set beats clear
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_cnt <= '0;
                end else if ((r_state == HS_WAIT) && (r_cnt != CNT_W'(TIMEOUT))) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_err_set) begin
                    r_err <= 1'b1;
                end else if (hs.err_clr_i) begin
                    r_err <= 1'b0;
                end
            end
        end

        assign hs.err_o = r_err;
    end else begin : g_no_timeout
        logic w_unused_err_clr;
        assign w_unused_err_clr = hs.err_clr_i;
        assign hs.err_o         = 1'b0;
    end

    assign hs.src_ready_o = w_ready;
    assign hs.cdc_req_o   = r_req;
    assign hs.cdc_data_o  = r_data;
    assign hs.busy_o      = (r_state == HS_WAIT);

endmodule : cdc_hs_src

// File: tb/tb_cdc_hs_src.sv
// Directed and randomised checks of the source-side toggle handshake.
module tb_cdc_hs_src;

    localparam int unsigned DW      = 32;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned TMO     = 8;
    localparam int          N_WORDS = 2000;
    localparam int          MAX_CYC = 60000;

    logic clk;
    logic rst;

    int checks_total;
    int checks_pass;

    cdc_hs_src_if #(.DATA_WIDTH(DW)) u_if ();

    cdc_hs_src #(
        .DATA_WIDTH (DW),
        .SYNC_STAGE (SYNC),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hs    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        u_if.src_valid_i   = 1'b0;
        u_if.src_data_i    = '0;
        u_if.cdc_ack_i     = 1'b0;
        u_if.err_clr_i     = 1'b0;
        tick();
        tick();
        checks_total++;
        if (u_if.cdc_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", u_if.cdc_req_o);
        else checks_pass++;
        checks_total++;
        if (u_if.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", u_if.busy_o);
        else checks_pass++;
        checks_total++;
        if (u_if.err_o !== 1'b0) $display("FAIL reset_err got %b want 0", u_if.err_o);
        else checks_pass++;
        checks_total++;
        if (u_if.cdc_data_o !== 32'h0) $display("FAIL reset_data got %h want 0", u_if.cdc_data_o);
        else checks_pass++;
        rst = 1'b0;
        tick();
        checks_total++;
        if (u_if.src_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", u_if.src_ready_o);
        else checks_pass++;
    endtask

    task automatic test_first_word();
        u_if.src_valid_i = 1'b1;
        u_if.src_data_i  = 32'hA5A5_0001;
        tick();
        u_if.src_valid_i = 1'b0;
        u_if.src_data_i  = 32'hDEAD_BEEF;
        checks_total++;
        if (u_if.cdc_req_o !== 1'b1) $display("FAIL w1_req got %b want 1", u_if.cdc_req_o);
        else checks_pass++;
        checks_total++;
        if (u_if.busy_o !== 1'b1) $display("FAIL w1_busy got %b want 1", u_if.busy_o);
        else checks_pass++;
        checks_total++;
        if (u_if.src_ready_o !== 1'b0) $display("FAIL w1_ready got %b want 0", u_if.src_ready_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (u_if.cdc_data_o !== 32'hA5A5_0001)
            $display("FAIL w1_data_hold got %h want a5a50001", u_if.cdc_data_o);
        else checks_pass++;
    endtask

    task automatic test_ack_complete();
        u_if.cdc_ack_i = 1'b1;
        tick();
        tick();
        checks_total++;
        if (u_if.busy_o !== 1'b1) $display("FAIL ack_busy_early got %b want 1", u_if.busy_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (u_if.busy_o !== 1'b0) $display("FAIL ack_busy_fall got %b want 0", u_if.busy_o);
        else checks_pass++;
        checks_total++;
        if (u_if.src_ready_o !== 1'b1) $display("FAIL ack_ready got %b want 1", u_if.src_ready_o);
        else checks_pass++;
        u_if.src_valid_i = 1'b1;
        u_if.src_data_i  = 32'h0000_0002;
        tick();
        u_if.src_valid_i = 1'b0;
        u_if.src_data_i  = 32'h1234_5678;
        checks_total++;
        if (u_if.cdc_req_o !== 1'b0) $display("FAIL w2_req got %b want 0", u_if.cdc_req_o);
        else checks_pass++;
        checks_total++;
        if (u_if.cdc_data_o !== 32'h0000_0002) $display("FAIL w2_data got %h want 2", u_if.cdc_data_o);
        else checks_pass++;
        u_if.cdc_ack_i = 1'b0;
        tick();
        tick();
        tick();
        checks_total++;
        if (u_if.busy_o !== 1'b0) $display("FAIL w2_done got %b want 0", u_if.busy_o);
        else checks_pass++;
    endtask

    task automatic test_spurious_ack();
        u_if.cdc_ack_i = 1'b1;
        tick();
        tick();
        checks_total++;
        if (u_if.src_ready_o !== 1'b0) $display("FAIL spur_ready_drop got %b want 0", u_if.src_ready_o);
        else checks_pass++;
        u_if.src_valid_i = 1'b1;
        u_if.src_data_i  = 32'h0000_0033;
        tick();
        tick();
        u_if.src_valid_i = 1'b0;
        checks_total++;
        if (u_if.cdc_req_o !== 1'b0) $display("FAIL spur_req got %b want 0", u_if.cdc_req_o);
        else checks_pass++;
        checks_total++;
        if (u_if.busy_o !== 1'b0) $display("FAIL spur_busy got %b want 0", u_if.busy_o);
        else checks_pass++;
        checks_total++;
        if (u_if.cdc_data_o !== 32'h0000_0002) $display("FAIL spur_data got %h want 2", u_if.cdc_data_o);
        else checks_pass++;
        u_if.cdc_ack_i = 1'b0;
        tick();
        tick();
        checks_total++;
        if (u_if.src_ready_o !== 1'b1) $display("FAIL spur_ready_back got %b want 1", u_if.src_ready_o);
        else checks_pass++;
    endtask

    task automatic test_timeout();
        u_if.src_valid_i = 1'b1;
        u_if.src_data_i  = 32'h0000_0044;
        tick();
        u_if.src_valid_i = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            checks_total++;
            if (u_if.err_o !== 1'b0) $display("FAIL tmo_early cyc %0d got %b want 0", k, u_if.err_o);
            else checks_pass++;
        end
        tick();
        checks_total++;
        if (u_if.err_o !== 1'b1) $display("FAIL tmo_set got %b want 1", u_if.err_o);
        else checks_pass++;
        tick();
        tick();
        checks_total++;
        if (u_if.busy_o !== 1'b1) $display("FAIL tmo_busy got %b want 1", u_if.busy_o);
        else checks_pass++;
        u_if.err_clr_i = 1'b1;
        tick();
        u_if.err_clr_i = 1'b0;
        checks_total++;
        if (u_if.err_o !== 1'b0) $display("FAIL tmo_clr got %b want 0", u_if.err_o);
        else checks_pass++;
        tick();
        checks_total++;
        if (u_if.err_o !== 1'b1) $display("FAIL tmo_reset got %b want 1", u_if.err_o);
        else checks_pass++;
    endtask

    task automatic test_reset_mid_wait();
        u_if.cdc_ack_i = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks_total++;
        if (u_if.cdc_req_o !== 1'b0) $display("FAIL rstw_req got %b want 0", u_if.cdc_req_o);
        else checks_pass++;
        checks_total++;
        if (u_if.busy_o !== 1'b0) $display("FAIL rstw_busy got %b want 0", u_if.busy_o);
        else checks_pass++;
        checks_total++;
        if (u_if.err_o !== 1'b0) $display("FAIL rstw_err got %b want 0", u_if.err_o);
        else checks_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        checks_total++;
        if (u_if.src_ready_o !== 1'b0) $display("FAIL rstw_ready_low got %b want 0", u_if.src_ready_o);
        else checks_pass++;
        u_if.cdc_ack_i = 1'b0;
        tick();
        tick();
        checks_total++;
        if (u_if.src_ready_o !== 1'b1) $display("FAIL rstw_ready_back got %b want 1", u_if.src_ready_o);
        else checks_pass++;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] want;
        logic          dest_seen;
        logic          pending;
        int            ack_dly;
        int            accepted;
        int            received;
        int            cyc;
        dest_seen = 1'b0;
        pending   = 1'b0;
        ack_dly   = 0;
        accepted  = 0;
        received  = 0;
        cyc       = 0;
        while ((received < N_WORDS) && (cyc < MAX_CYC)) begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                ack_dly--;
                if (ack_dly == 0) begin
                    u_if.cdc_ack_i = dest_seen;
                    pending        = 1'b0;
                end
            end else if (u_if.cdc_req_o !== dest_seen) begin
                dest_seen = u_if.cdc_req_o;
                want      = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                checks_total++;
                if (u_if.cdc_data_o !== want)
                    $display("FAIL rand_word %0d got %h want %h", received, u_if.cdc_data_o, want);
                else checks_pass++;
                received++;
                pending = 1'b1;
                ack_dly = int'($urandom_range(1, 4));
            end
            u_if.src_valid_i = 1'($urandom_range(0, 1));
            u_if.src_data_i  = $urandom();
            if (u_if.src_valid_i && u_if.src_ready_o) begin
                exp_q.push_back(u_if.src_data_i);
                accepted++;
            end
        end
        u_if.src_valid_i = 1'b0;
        checks_total++;
        if (received !== N_WORDS) $display("FAIL rand_count got %0d want %0d", received, N_WORDS);
        else checks_pass++;
        checks_total++;
        if (accepted !== received) $display("FAIL rand_drop accepted %0d received %0d", accepted, received);
        else checks_pass++;
    endtask

    initial begin
        checks_total = 0;
        checks_pass  = 0;
        test_reset();
        test_first_word();
        test_ack_complete();
        test_spurious_ack();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule : tb_cdc_hs_src
